// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizing helpers for the multiplier BCD display path
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction
  // smallest digit count whose decimal range covers the full product range
  function automatic int bcd_digits(input int width);
    longint max_v, p;
    int d;
    max_v = (longint'(1) << (2 * width)) - 1;
    p = 1;
    d = 0;
    for (int i = 0; i < 18; i++) begin
      if (p <= max_v) begin
        p = p * 10;
        d++;
      end
    end
    return d;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble correction, adds 3 to a BCD digit of 5 or more
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = din >= 4'd5 ? din + 4'd3 : din;
endmodule

// File: rtl/mult_bcd_converter.sv
// mult_bcd_converter: sequential double-dabble of the multiplier product into packed BCD
module mult_bcd_converter
  import mult_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*WIDTH-1:0]        bin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*DIGITS-1:0]       bcd_out
);
  localparam int PW = prod_w(WIDTH);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(PW + 1);
  localparam logic [CW-1:0] LAST = CW'(PW - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] bin_sr;
  logic [BW-1:0] bcd_sr, adj;
  if (DIGITS < bcd_digits(WIDTH)) begin : g_chk
    $error("DIGITS too small to hold the largest product");
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.din(bcd_sr[4*g +: 4]), .dout(adj[4*g +: 4]));
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          bin_sr <= bin_in;
          bcd_sr <= '0;
          cnt    <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {adj, bin_sr} << 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state   <= DONE;
            bcd_out <= {adj[BW-2:0], bin_sr[PW-1]};
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_bcd_converter.sv
// tb_mult_bcd_converter: scoreboard bench for the product-to-BCD converter
module tb_mult_bcd_converter;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, rand_stall = 0;
  logic [7:0] bin_in = '0;
  logic in_ready, out_valid;
  logic [11:0] bcd_out;
  logic [11:0] sb[$];
  int total = 0, bad = 0;

  mult_bcd_converter #(.WIDTH(4), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // scoreboard: push on accept, pop on consume; sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(ref_bcd(int'(bin_in)));
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got=%h expected=none", bcd_out);
        end else begin
          logic [11:0] e;
          e = sb.pop_front();
          if (bcd_out !== e) begin
            bad++;
            $display("FAIL result got=%h expected=%h", bcd_out, e);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_stall) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout got=0 expected=1");
    end
  endtask

  // accepts v and returns cycles from accept edge until out_valid rises
  task automatic send(input int v, output int lat);
    wait_ready();
    in_valid = 1;
    bin_in = 8'(v);
    tick();
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #13;
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b expected=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
    if (bcd_out !== 12'h000) begin bad++; $display("FAIL reset_bcd got=%h expected=000", bcd_out); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    int vals[4] = '{0, 225, 99, 100};
    int lat;
    out_ready = 1;
    foreach (vals[i]) begin
      send(vals[i], lat);
      total++;
      if (lat !== 8) begin bad++; $display("FAIL latency_%0d got=%0d expected=8", vals[i], lat); end
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_%0d got=%b expected=0", vals[i], out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 0;
    send(255, lat);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (out_valid !== 1'b1 || bcd_out !== 12'h255 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle_%0d got=v%b r%b %h expected=v1 r0 255", i, out_valid, in_ready, bcd_out);
      end
      tick();
    end
    out_ready = 1;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release got=v%b r%b expected=v0 r1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    wait_ready();
    in_valid = 1;
    bin_in = 8'd200;
    tick();
    in_valid = 0;
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b expected=0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b expected=1", in_ready); end
    if (bcd_out !== 12'h000) begin bad++; $display("FAIL midrst_bcd got=%h expected=000", bcd_out); end
    sb.delete();
    tick();
    tick();
    rst_n = 1;
    tick();
    send(7, lat);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL latency_after_reset got=%0d expected=8", lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    int t0 = -1, t1 = -1, nv = 0;
    out_ready = 1;
    wait_ready();
    in_valid = 1;
    bin_in = 8'd42;
    for (int c = 0; c < 30; c++) begin
      if (in_ready && t0 < 0) t0 = c;
      else if (in_ready && t1 < 0) t1 = c;
      if (out_valid) nv++;
      tick();
      if (t0 >= 0) bin_in = 8'd37;
      if (t1 >= 0) in_valid = 0;
    end
    total += 2;
    if (t1 - t0 !== 10) begin bad++; $display("FAIL b2b_gap got=%0d expected=10", t1 - t0); end
    if (nv !== 2) begin bad++; $display("FAIL b2b_valid_cycles got=%0d expected=2", nv); end
  endtask

  task automatic test_sweep();
    int n = 0;
    rand_stall = 1;
    for (int v = 0; v < 256; v++) begin
      wait_ready();
      in_valid = 1;
      bin_in = 8'(v);
      tick();
      in_valid = 0;
    end
    rand_stall = 0;
    out_ready = 1;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL sweep_drain got=%0d expected=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
